// File: rtl/imm_pack_if.sv
// Handshake bundle for imm_pack: input beat (valid/ready/op/value) and
// output beat (valid/ready/field/err).
interface imm_pack_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_value;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_field;
  logic [1:0]  out_err;

  // Producer of input beats / consumer of output beats
  modport master (
    output in_valid, in_op, in_value, out_ready,
    input  in_ready, out_valid, out_field, out_err
  );

  // The packer itself
  modport slave (
    input  in_valid, in_op, in_value, out_ready,
    output in_ready, out_valid, out_field, out_err
  );
endinterface

// File: rtl/imm_pack.sv
// Immediate/offset field packer: narrows a 32-bit immediate or branch byte
// offset into its instruction field and flags values that would not
// sign-extend back to the original. Two-stage valid/ready pipeline with a
// saturating count of errored output beats.
module imm_pack #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  imm_pack_if.slave        bus,
  input  logic             clear_count,
  output logic [CNT_W-1:0] err_count
);

  logic        s1_valid;
  logic [1:0]  s1_op;
  logic [31:0] s1_value;
  logic        s2_valid;
  logic        s1_adv;
  logic        s2_adv;
  logic [23:0] pk_field;
  logic [1:0]  pk_err;
  logic        imm_fits;
  logic        br_fits;
  logic        err_xfer;

  assign s2_adv        = !s2_valid || bus.out_ready;
  assign s1_adv        = !s1_valid || s2_adv;
  assign bus.in_ready  = rst_n && s1_adv;
  assign bus.out_valid = s2_valid;
  assign err_xfer      = s2_valid && bus.out_ready && (bus.out_err != 2'b00);

  // Range checks: all bits above the field's sign bit must match it
  assign imm_fits = (&s1_value[31:11]) || !(|s1_value[31:11]);
  assign br_fits  = (&s1_value[31:25]) || !(|s1_value[31:25]);

  // Field packing and error classification (bad op > misaligned > range)
  always_comb begin
    pk_field = '0;
    pk_err   = 2'b00;
    if (s1_op == 2'b11) begin
      pk_err = 2'b11;
    end else if (s1_op == 2'b10) begin
      if (s1_value[1:0] != 2'b00)
        pk_err = 2'b10;
      else if (!br_fits)
        pk_err = 2'b01;
      else
        pk_field = s1_value[25:2];
    end else begin
      if (!imm_fits)
        pk_err = 2'b01;
      else
        pk_field = {12'h000, s1_value[11:0]};
    end
  end

  // Stage 1: capture the raw input beat when the stage can advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_value <= '0;
    end else if (s1_adv) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_op    <= bus.in_op;
        s1_value <= bus.in_value;
      end
    end
  end

  // Stage 2: output register, held while the beat waits for out_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid      <= 1'b0;
      bus.out_field <= '0;
      bus.out_err   <= 2'b00;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        bus.out_field <= pk_field;
        bus.out_err   <= pk_err;
      end
    end
  end

  // Saturating count of errored output transfers; clear has priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_count <= '0;
    else if (clear_count)
      err_count <= '0;
    else if (err_xfer && (err_count != '1))
      err_count <= err_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_imm_pack.sv
// Self-checking bench for imm_pack: scoreboard of expected {err, field}
// pushed on input acceptance and popped on each output transfer.
module tb_imm_pack;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear_count = 1'b0;
  logic [15:0] err_count;
  logic        clear2 = 1'b0;
  logic [1:0]  err_count2;

  imm_pack_if bus ();
  imm_pack_if bus2 ();

  imm_pack #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .clear_count(clear_count), .err_count(err_count)
  );

  imm_pack #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2.slave),
    .clear_count(clear2), .err_count(err_count2)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          n_errexp = 0;
  logic [25:0] q[$];
  bit          auto_push = 1'b0;

  // Reference: {err, field} from signed range arithmetic
  function automatic logic [25:0] model(input logic [1:0] op, input logic [31:0] v);
    int s;
    s = $signed(v);
    if (op == 2'b11) return {2'b11, 24'h0};
    if (op == 2'b10) begin
      if (v[1:0] != 2'b00) return {2'b10, 24'h0};
      if (s < -(1 << 25) || s > (1 << 25) - 1) return {2'b01, 24'h0};
      return {2'b00, v[25:2]};
    end
    if (s < -2048 || s > 2047) return {2'b01, 24'h0};
    return {2'b00, 12'h000, v[11:0]};
  endfunction

  // Scoreboard monitor: sample mid-cycle, transfers complete on next posedge
  always @(negedge clk) begin
    if (rst_n) begin
      if (auto_push && bus.in_valid && bus.in_ready)
        q.push_back(model(bus.in_op, bus.in_value));
      if (bus.out_valid && bus.out_ready) begin
        logic [25:0] e;
        n_cmp++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_empty: got field=%h err=%b, expected no beat", bus.out_field, bus.out_err);
        end else begin
          e = q.pop_front();
          if (e[25:24] != 2'b00) n_errexp++;
          if ({bus.out_err, bus.out_field} !== e) begin
            n_fail++;
            $display("FAIL sb_out: got field=%h err=%b, expected field=%h err=%b",
                     bus.out_field, bus.out_err, e[23:0], e[25:24]);
          end
        end
      end
    end
  end

  task automatic drain(input string tag);
    for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_%s: got %0d beats outstanding, expected 0", tag, q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({bus.in_ready, bus.out_valid, bus.out_field, bus.out_err, err_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b vld=%b field=%h err=%b cnt=%0d, expected all 0",
               bus.in_ready, bus.out_valid, bus.out_field, bus.out_err, err_count);
    end
    @(negedge clk); rst_n = 1'b1;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got in_ready=%b, expected 1", bus.in_ready);
    end
  endtask

  task automatic test_imm();
    logic [31:0] vals[4];
    logic [25:0] exps[4];
    vals = '{32'h0000_07FF, 32'hFFFF_F800, 32'h0000_0800, 32'hFFFF_F7FF};
    exps = '{{2'b00, 24'h0007FF}, {2'b00, 24'h000800}, {2'b01, 24'h0}, {2'b01, 24'h0}};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1; bus.in_op = 2'b00; bus.in_value = vals[i];
      @(negedge clk);
      n_cmp++;
      if (bus.in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL imm_accept[%0d]: got in_ready=%b, expected 1", i, bus.in_ready);
      end
      q.push_back(exps[i]);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL imm_lat_early[%0d]: got out_valid=%b, expected 0", i, bus.out_valid);
      end
      @(posedge clk); @(negedge clk);
      n_cmp++;
      if (bus.out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL imm_lat[%0d]: got out_valid=%b, expected 1", i, bus.out_valid);
      end
    end
    drain("imm");
  endtask

  task automatic test_branch();
    logic [1:0]  ops[7];
    logic [31:0] vals[7];
    logic [25:0] exps[7];
    ops  = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b10};
    vals = '{32'hFFFF_FFF8, 32'h01FF_FFFC, 32'hFE00_0000, 32'h0200_0000,
             32'h0000_0006, 32'h0000_0000, 32'h0200_0002};
    exps = '{{2'b00, 24'hFFFFFE}, {2'b00, 24'h7FFFFF}, {2'b00, 24'h800000},
             {2'b01, 24'h0}, {2'b10, 24'h0}, {2'b11, 24'h0}, {2'b10, 24'h0}};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1; bus.in_op = ops[i]; bus.in_value = vals[i];
      @(negedge clk);
      n_cmp++;
      if (bus.in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL br_accept[%0d]: got in_ready=%b, expected 1", i, bus.in_ready);
      end
      q.push_back(exps[i]);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    drain("branch");
  endtask

  task automatic test_backpressure();
    logic [1:0]  ops[4];
    logic [31:0] vals[4];
    logic [23:0] held;
    int k, outs, first, last;
    ops  = '{2'b00, 2'b10, 2'b00, 2'b10};
    vals = '{32'h0000_0123, 32'h0000_0100, 32'h0000_0800, 32'h0000_0007};
    k = 0; outs = 0; first = -1; last = -1; held = '0;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1; bus.in_op = ops[k]; bus.in_value = vals[k];
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(model(ops[k], vals[k]));
        k++;
      end
      if (c == 2) held = bus.out_field;
    end
    n_cmp++;
    if (k !== 2) begin
      n_fail++;
      $display("FAIL bp_accepted: got %0d beats, expected 2", k);
    end
    n_cmp++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_full: got in_ready=%b out_valid=%b, expected 0 1", bus.in_ready, bus.out_valid);
    end
    n_cmp++;
    if (bus.out_field !== held || held !== 24'h000123) begin
      n_fail++;
      $display("FAIL bp_stable: got field=%h (held %h), expected 000123", bus.out_field, held);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_ready_rise: got in_ready=%b, expected 1", bus.in_ready);
    end
    for (int c = 0; c < 10; c++) begin
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(model(ops[k], vals[k]));
        k++;
      end
      if (bus.out_valid && bus.out_ready) begin
        outs++;
        if (first < 0) first = c;
        last = c;
      end
      @(posedge clk); #1;
      if (k < 4) begin
        bus.in_op = ops[k]; bus.in_value = vals[k];
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (outs !== 4 || (last - first) !== 3) begin
      n_fail++;
      $display("FAIL bp_drain: got %0d outputs over span %0d, expected 4 over 3", outs, last - first);
    end
    drain("bp");
  endtask

  task automatic test_stream();
    int sent;
    logic [31:0] t;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; clear_count = 1'b1;
    @(posedge clk); #1;
    clear_count = 1'b0;
    n_cmp++;
    if (err_count !== 16'd0) begin
      n_fail++;
      $display("FAIL stream_clear: got err_count=%0d, expected 0", err_count);
    end
    n_errexp = 0;
    sent = 0;
    auto_push = 1'b1;
    for (int cyc = 0; cyc < 3000 && sent < 100; cyc++) begin
      if (cyc != 0) begin @(posedge clk); #1; end
      t = $urandom;
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_op     = 2'($urandom_range(0, 3));
      bus.out_ready = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 2))
        0:       bus.in_value = t;
        1:       bus.in_value = {{20{t[31]}}, t[11:0]};
        default: bus.in_value = {{6{t[31]}}, t[25:0]};
      endcase
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) sent++;
    end
    @(posedge clk); #1;
    auto_push = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    n_cmp++;
    if (sent !== 100) begin
      n_fail++;
      $display("FAIL stream_sent: got %0d accepted, expected 100", sent);
    end
    drain("stream");
    n_cmp++;
    if (err_count !== 16'(n_errexp)) begin
      n_fail++;
      $display("FAIL stream_errcnt: got %0d, expected %0d", err_count, n_errexp);
    end
  endtask

  task automatic test_counter();
    bus2.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      bus2.in_valid = 1'b1; bus2.in_op = 2'b11; bus2.in_value = '0;
    end
    @(posedge clk); #1;
    bus2.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (err_count2 !== 2'd3) begin
      n_fail++;
      $display("FAIL cnt_saturate: got %0d, expected 3", err_count2);
    end
    @(posedge clk); #1;
    bus2.in_valid = 1'b1; bus2.in_op = 2'b10; bus2.in_value = 32'h0000_0002;
    @(posedge clk); #1;
    bus2.in_valid = 1'b0;
    @(posedge clk); #1;
    clear2 = 1'b1;
    n_cmp++;
    if (bus2.out_valid !== 1'b1 || bus2.out_err !== 2'b10) begin
      n_fail++;
      $display("FAIL cnt_beat: got out_valid=%b err=%b, expected 1 10", bus2.out_valid, bus2.out_err);
    end
    @(posedge clk); #1;
    clear2 = 1'b0;
    n_cmp++;
    if (err_count2 !== 2'd0) begin
      n_fail++;
      $display("FAIL cnt_clear_wins: got %0d, expected 0", err_count2);
    end
    bus2.in_valid = 1'b1; bus2.in_op = 2'b00; bus2.in_value = 32'h0000_1000;
    @(posedge clk); #1;
    bus2.in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    n_cmp++;
    if (err_count2 !== 2'd1) begin
      n_fail++;
      $display("FAIL cnt_after_clear: got %0d, expected 1", err_count2);
    end
  endtask

  task automatic test_reset_mid();
    int stale;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1; bus.in_op = 2'b00; bus.in_value = 32'(i + 3);
      @(negedge clk);
      if (bus.in_ready) q.push_back(model(2'b00, 32'(i + 3)));
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || err_count === 16'd0) begin
      n_fail++;
      $display("FAIL rst_pre: got in_ready=%b out_valid=%b cnt=%0d, expected 0 1 nonzero",
               bus.in_ready, bus.out_valid, err_count);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.in_ready, bus.out_valid, bus.out_field, bus.out_err, err_count} !== '0) begin
      n_fail++;
      $display("FAIL rst_async: got rdy=%b vld=%b field=%h err=%b cnt=%0d, expected all 0",
               bus.in_ready, bus.out_valid, bus.out_field, bus.out_err, err_count);
    end
    q.delete();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.out_valid) stale++;
    end
    n_cmp++;
    if (stale !== 0) begin
      n_fail++;
      $display("FAIL rst_stale: got %0d stale beats, expected 0", stale);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_op = 2'b00; bus.in_value = 32'h0000_0005;
    @(negedge clk);
    if (bus.in_ready) q.push_back({2'b00, 24'h000005});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_lat_early: got out_valid=%b, expected 0", bus.out_valid);
    end
    @(posedge clk); @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_lat: got out_valid=%b, expected 1", bus.out_valid);
    end
    drain("rst");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_op = '0; bus.in_value = '0; bus.out_ready = 1'b1;
    bus2.in_valid = 1'b0; bus2.in_op = '0; bus2.in_value = '0; bus2.out_ready = 1'b1;
    test_reset();
    test_imm();
    test_branch();
    test_backpressure();
    test_stream();
    test_counter();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_pack.md
# imm_pack

Immediate/offset field packer: the inverse of the datapath sign extender. It takes a 32-bit signed immediate or a branch byte offset and produces the narrowed instruction field for the selected format. It also checks that the value is representable, so that sign-extending the field reproduces the original value exactly. It sits in the instruction-generation/loader path ahead of instruction memory, as a 2-stage valid/ready pipeline with a saturating error counter.

## Interface
- CNT_W, 16, width of err_count
- clk  in  1  clock, rising-edge
- rst_n  in  1  asynchronous reset, active-low
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat this cycle
- in_op  in  2  format: 00/01 = 12-bit immediate, 10 = 24-bit branch word offset, 11 = reserved
- in_value  in  32  signed immediate (op 00/01) or signed byte offset (op 10)
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts output beat
- out_field  out  24  packed field
- out_err  out  2  00 ok, 01 out of range, 10 misaligned, 11 bad op
- err_count  out  CNT_W  count of errored output beats, saturating
- clear_count  in  1  synchronous clear of err_count

## Operation
- op 00/01: legal iff in_value[31:11] are all equal. out_field = {12'h000, in_value[11:0]}.
- op 10: legal iff in_value[1:0] == 0 and in_value[31:25] are all equal. out_field = in_value[25:2].
- op 11: always error 11.
- Error priority: bad op (11) > misaligned (10) > range (01). Misaligned applies to op 10 only.
- On any error, out_field = 24'h000000.
- Stage 1 registers the input beat and computes the field and error. Stage 2 is the output register that drives out_*.
- Handshakes:
  - input transfer when in_valid && in_ready.
  - output transfer when out_valid && out_ready.
- Stage advance: s2_adv = !s2_valid || out_ready; s1_adv = !s1_valid || s2_adv.
- in_ready = s1_adv. This is combinational from out_ready and state, with no path from in_valid.
- Order is preserved; no beat is dropped or duplicated.
- out_valid is held high, and out_field/out_err are held stable, until the beat transfers.
- err_count increments on each output transfer with out_err != 00. It saturates at 2^CNT_W-1.
- clear_count sets err_count to 0 next edge. If clear and increment happen in the same cycle, clear wins (result 0).

## Timing
- Latency: a beat accepted at edge N is presented on out_valid after edge N+1, i.e. 2 registered stages.
- Throughput: 1 beat/cycle with out_ready held high.
- Capacity: 2 beats. With out_ready low, at most 2 beats are accepted, then in_ready drops.
  - in_ready rises combinationally in the same cycle out_ready rises while stage 2 is full.
- Reset (async assert, any cycle): s1_valid = s2_valid = 0, out_valid = 0, out_field = 0, out_err = 00, err_count = 0.
  - in_ready = 1 while rst_n = 1 after reset.
  - In-flight beats are discarded.
  - While rst_n = 0, in_ready = 0.
- Deassertion is synchronised by the system. The first transfer may occur on the first edge after rst_n goes high.
- No combinational path from in_* to out_*.

## Test plan
- Immediate range, op 00, out_ready = 1:
  - 0x000007FF -> field 0x0007FF, err 00.
  - 0xFFFFF800 -> 0x000800, err 00.
  - 0x00000800 -> 0x000000, err 01.
  - 0xFFFFF7FF -> err 01.
  - Each out_valid appears 2 cycles after acceptance.
- Branch, op 10:
  - 0xFFFFFFF8 -> 0xFFFFFE, err 00.
  - 0x01FFFFFC -> 0x7FFFFF, err 00.
  - 0xFE000000 -> 0x800000, err 00.
  - 0x02000000 -> err 01.
  - 0x00000006 -> err 10.
  - op 11 with 0x0 -> err 11.
  - 0x02000002 (op 10) -> err 10, confirming priority over range.
- Backpressure: out_ready = 0, in_valid held with 4 distinct beats.
  - Exactly 2 beats accepted, then in_ready = 0.
  - out_field stays stable.
  - Raise out_ready: all 4 beats exit in order, back-to-back, with none lost or duplicated.
- Streaming: 100 random beats with random in_valid/out_ready.
  - Outputs match a reference model in order.
  - err_count equals the number of errored beats.
- Counter, CNT_W = 2:
  - 5 errored beats -> err_count = 3 (saturated).
  - clear_count pulse coinciding with an errored transfer -> err_count = 0.
  - Next errored transfer -> 1.
- Reset mid-stream: assert rst_n = 0 with both stages full and out_ready = 0.
  - Outputs zero asynchronously, before the next edge.
  - After release, no stale beat appears and the first new beat exits after 2 cycles.
